// File: rtl/fht_input_loader.sv
// ============================================================================
// fht_input_loader
// ----------------------------------------------------------------------------
// Purpose
//   Frame loader that sits directly upstream of fht_top. ADC samples arrive
//   over a valid/ready handshake. Each frame of N = 4*2^A_BIT samples is
//   scattered across the four FHT RAM banks. An optional bit-reversal of the
//   sample index is applied before the bank/address split. Once the whole
//   frame has been written, a one-cycle start pulse is issued. The next frame
//   is then held off until the transform reports completion.
//
// Parameters
//   D_BIT      FHT data width (signed)
//   ADC_WIDTH  incoming ADC sample width (signed two's complement)
//   A_BIT      address width per bank; N = 4*2^A_BIT samples per frame
//   BITREV     1: sample index is bit-reversed (A_BIT+2 bits) before mapping
//   IN_SHIFT   left shift applied after sign extension
//
// Ports
//   iCLK       in   clock, all logic on the rising edge
//   iRESET     in   synchronous active-high reset
//   iADC_DATA  in   ADC sample
//   iVALID     in   sample valid
//   oREADY     out  loader can accept a sample this cycle (IDLE/LOAD only)
//   iFHT_RDY   in   fht_top.oRDY level (high = transform done/idle)
//   iCLR_DROP  in   clears the oDROP sticky flag
//   oWE        out  one-hot bank write enable -> fht_top.iWE
//   oDATA      out  write data, broadcast to all banks
//   oADDR_WR   out  write address, broadcast to all banks
//   oSTART     out  one-cycle start pulse -> fht_top.iSTART
//   oBUSY      out  high from first accepted sample until transform done
//   oDROP      out  sticky: a sample was offered while oREADY was low
// ============================================================================
module fht_input_loader #(
    parameter int D_BIT     = 16,
    parameter int ADC_WIDTH = 12,
    parameter int A_BIT     = 8,
    parameter int BITREV    = 0,
    parameter int IN_SHIFT  = 0
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic [ADC_WIDTH-1:0] iADC_DATA,
    input  logic                 iVALID,
    output logic                 oREADY,
    input  logic                 iFHT_RDY,
    input  logic                 iCLR_DROP,
    output logic [3:0]           oWE,
    output logic [D_BIT-1:0]     oDATA,
    output logic [A_BIT-1:0]     oADDR_WR,
    output logic                 oSTART,
    output logic                 oBUSY,
    output logic                 oDROP
);

    // Sample index width: two bank-select bits plus the per-bank address.
    localparam int             K_W    = A_BIT + 2;
    localparam logic [K_W-1:0] K_ONE  = K_W'(1);
    localparam logic [K_W-1:0] K_LAST = '1;

    // A shifted sample must fit in the FHT word; there is no saturation.
    if (ADC_WIDTH + IN_SHIFT > D_BIT) begin : g_width_check
        $error("fht_input_loader: ADC_WIDTH + IN_SHIFT exceeds D_BIT");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_ACK,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [K_W-1:0]      r_k;
    logic [3:0]          r_we;
    logic [D_BIT-1:0]    r_data;
    logic [A_BIT-1:0]    r_addr;
    logic                r_start;
    logic                r_drop;

    logic                w_ready;
    logic                w_accept;
    logic                w_last;
    logic [K_W-1:0]      w_r;
    logic signed [D_BIT-1:0] w_ext;
    logic signed [D_BIT-1:0] w_data;

    // Ready is decoded from the state. It is forced low while reset is
    // asserted, so no sample is taken on the reset edge.
    assign w_ready  = ~iRESET & ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_accept = iVALID & w_ready;
    assign w_last   = (r_k == K_LAST);

    // Index mapping: optional full-width bit reversal of the sample index.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        w_r = r_k;
        if (BITREV != 0) begin
            for (int i = 0; i < K_W; i++) begin
                w_r[i] = r_k[K_W-1-i];
            end
        end
    end

    // A size cast of a signed operand sign-extends to the FHT width. Once
    // extended, a left shift is the same for signed and unsigned operands.
    assign w_ext  = D_BIT'($signed(iADC_DATA));
    assign w_data = w_ext <<< IN_SHIFT;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_we    <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_start <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every branch below sees the pre-edge values of all registers.
            r_we    <= '0;
            r_start <= 1'b0;

            // Write path: one registered write per accepted sample. Data
            // and address hold their last value between writes.
            if (w_accept) begin
                r_we   <= 4'b0001 << w_r[1:0];
                r_data <= w_data;
                r_addr <= w_r[K_W-1:2];
                r_k    <= r_k + K_ONE;   // wraps to 0 on the last sample
            end

            // Sticky drop flag. Set has priority over clear.
            if (iVALID && !w_ready) begin
                r_drop <= 1'b1;
            end else if (iCLR_DROP) begin
                r_drop <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept && w_last) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    // Entered while the last write is on the bus. The pulse
                    // therefore lands one cycle after the last write.
                    r_start <= 1'b1;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    // A high level here can be left over from the previous
                    // transform. Wait for the FHT to report busy first.
                    if (!iFHT_RDY) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (iFHT_RDY) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oREADY   = w_ready;
    assign oBUSY    = ~iRESET & (r_state != S_IDLE);
    assign oWE      = r_we;
    assign oDATA    = r_data;
    assign oADDR_WR = r_addr;
    assign oSTART   = r_start;
    assign oDROP    = r_drop;

endmodule

// File: tb/tb_fht_input_loader.sv
// ============================================================================
// tb_fht_input_loader
// ----------------------------------------------------------------------------
// Directed bench for fht_input_loader with A_BIT=2 (N=16).
// Two instances share every input:
//   u_dut0  BITREV=0, IN_SHIFT=0
//   u_dut1  BITREV=1, IN_SHIFT=2
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// at that same point, which is well away from the active edge.
// ============================================================================
module tb_fht_input_loader;

    localparam int D_BIT     = 16;
    localparam int ADC_WIDTH = 12;
    localparam int A_BIT     = 2;
    localparam int N         = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ADC_WIDTH-1:0] adc;
    logic                 valid;
    logic                 fht_rdy;
    logic                 clr_drop;

    logic                 ready0, start0, busy0, drop0;
    logic [3:0]           we0;
    logic [D_BIT-1:0]     data0;
    logic [A_BIT-1:0]     addr0;
    logic                 ready1, start1, busy1, drop1;
    logic [3:0]           we1;
    logic [D_BIT-1:0]     data1;
    logic [A_BIT-1:0]     addr1;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-written 4-bit bit-reversal table.
    int bitrev_tbl [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always #5 clk = ~clk;

    fht_input_loader #(
        .D_BIT(D_BIT), .ADC_WIDTH(ADC_WIDTH), .A_BIT(A_BIT), .BITREV(0), .IN_SHIFT(0)
    ) u_dut0 (
        .iCLK(clk), .iRESET(rst), .iADC_DATA(adc), .iVALID(valid), .oREADY(ready0),
        .iFHT_RDY(fht_rdy), .iCLR_DROP(clr_drop), .oWE(we0), .oDATA(data0),
        .oADDR_WR(addr0), .oSTART(start0), .oBUSY(busy0), .oDROP(drop0)
    );

    fht_input_loader #(
        .D_BIT(D_BIT), .ADC_WIDTH(ADC_WIDTH), .A_BIT(A_BIT), .BITREV(1), .IN_SHIFT(2)
    ) u_dut1 (
        .iCLK(clk), .iRESET(rst), .iADC_DATA(adc), .iVALID(valid), .oREADY(ready1),
        .iFHT_RDY(fht_rdy), .iCLR_DROP(clr_drop), .oWE(we1), .oDATA(data1),
        .oADDR_WR(addr1), .oSTART(start1), .oBUSY(busy1), .oDROP(drop1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sign-extend 12 -> 16 bits, then shift.
    function automatic logic [15:0] ext(input logic [11:0] v, input int sh);
        logic [15:0] e;
        e = {{4{v[11]}}, v};
        return e << sh;
    endfunction

    // Offer sample k with value v for one cycle and check the resulting write.
    task automatic write_sample(input int k, input logic [11:0] v);
        logic [3:0] exp_we0, exp_we1;
        int r;
        valid = 1'b1;
        adc   = v;
        tick();
        r       = bitrev_tbl[k];
        exp_we0 = 4'b0001 << (k % 4);
        exp_we1 = 4'b0001 << (r % 4);
        check($sformatf("we0[%0d]", k),   32'(we0),   32'(exp_we0));
        check($sformatf("addr0[%0d]", k), 32'(addr0), 32'(k / 4));
        check($sformatf("data0[%0d]", k), 32'(data0), 32'(ext(v, 0)));
        check($sformatf("we1[%0d]", k),   32'(we1),   32'(exp_we1));
        check($sformatf("addr1[%0d]", k), 32'(addr1), 32'(r / 4));
        check($sformatf("data1[%0d]", k), 32'(data1), 32'(ext(v, 2)));
        check($sformatf("busy0[%0d]", k), 32'(busy0), 32'd1);
        check($sformatf("ready0[%0d]", k), 32'(ready0), (k == N - 1) ? 32'd0 : 32'd1);
    endtask

    initial begin
        int starts;
        logic [11:0] v;

        rst      = 1'b1;
        adc      = '0;
        valid    = 1'b0;
        fht_rdy  = 1'b1;
        clr_drop = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_ready", 32'(ready0), 32'd0);
        check("rst_busy",  32'(busy0),  32'd0);
        check("rst_we",    32'(we0),    32'd0);
        check("rst_data",  32'(data0),  32'd0);
        check("rst_addr",  32'(addr0),  32'd0);
        check("rst_start", 32'(start0), 32'd0);
        check("rst_drop",  32'(drop0),  32'd0);

        rst = 1'b0;
        tick();
        check("idle_ready", 32'(ready0), 32'd1);
        check("idle_busy",  32'(busy0),  32'd0);

        // ---------------- frame 1: back-to-back, sign extremes ----------------
        for (int k = 0; k < N; k++) begin
            if (k == 0)      v = 12'h800;
            else if (k == 1) v = 12'h7FF;
            else             v = 12'(k * 'h111);
            write_sample(k, v);
        end
        valid = 1'b0;
        // Spot values for the shift and bit-reversal corners.
        check("ext_800_sh2", 32'(ext(12'h800, 2)), 32'h0000_E000);
        check("ext_7ff_sh2", 32'(ext(12'h7FF, 2)), 32'h0000_1FFC);
        check("start_early", 32'(start0), 32'd0);

        // Last accept -> write -> start, two cycles after the accept.
        tick();
        check("start_pulse0", 32'(start0), 32'd1);
        check("start_pulse1", 32'(start1), 32'd1);
        check("start_we",     32'(we0),    32'd0);
        check("start_ready",  32'(ready0), 32'd0);

        // ---------------- ACK with stale high FHT ready, drops ----------------
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ack_start[%0d]", i), 32'(start0), 32'd0);
            check($sformatf("ack_ready[%0d]", i), 32'(ready0), 32'd0);
            check($sformatf("ack_we[%0d]", i),    32'(we0 | we1), 32'd0);
            check($sformatf("ack_busy[%0d]", i),  32'(busy0), 32'd1);
            check($sformatf("ack_drop[%0d]", i),  32'(drop0), 32'd1);
        end

        // ---------------- DONE: FHT running for 20 cycles ----------------
        fht_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                valid    = 1'b1;   // set and clear together: set wins
                clr_drop = 1'b1;
            end else if (i == 1) begin
                valid    = 1'b0;
                clr_drop = 1'b1;
            end else begin
                valid    = 1'b0;
                clr_drop = 1'b0;
            end
            tick();
            check($sformatf("done_ready[%0d]", i), 32'(ready0), 32'd0);
            check($sformatf("done_we[%0d]", i),    32'(we0 | we1), 32'd0);
            if (i == 0) check("drop_set_wins", 32'(drop0), 32'd1);
            if (i == 1) check("drop_cleared",  32'(drop0), 32'd0);
        end
        clr_drop = 1'b0;
        fht_rdy  = 1'b1;
        check("pre_rise_ready", 32'(ready0), 32'd0);
        tick();
        check("post_rise_ready", 32'(ready0), 32'd1);
        check("post_rise_busy",  32'(busy0),  32'd0);

        // ---------------- frame 2: gap, then reset after 7 samples ----------------
        for (int k = 0; k < 7; k++) begin
            if (k == 4) begin
                valid = 1'b0;
                tick();
                check("gap_we0",  32'(we0),   32'd0);
                check("gap_we1",  32'(we1),   32'd0);
                check("gap_busy", 32'(busy0), 32'd1);
            end
            write_sample(k, 12'(k * 'h0A5 + 1));
        end
        rst   = 1'b1;
        valid = 1'b1;
        tick();
        tick();
        check("mid_rst_ready", 32'(ready0 | ready1), 32'd0);
        check("mid_rst_busy",  32'(busy0 | busy1),   32'd0);
        check("mid_rst_we",    32'(we0 | we1),       32'd0);
        check("mid_rst_data",  32'(data0 | data1),   32'd0);
        check("mid_rst_addr",  32'(addr0 | addr1),   32'd0);
        check("mid_rst_start", 32'(start0 | start1), 32'd0);
        check("mid_rst_drop",  32'(drop0 | drop1),   32'd0);

        // ---------------- frame 3: full frame after reset ----------------
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            write_sample(k, 12'(k * 'h0F3 + 5));
        end
        valid  = 1'b0;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (start0) starts++;
        end
        check("start_count", 32'(starts), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
